craft_round_ctrl: RTL and testbench

Round sequencer for the nibble-serial CRAFT core. It accepts a start request and steps the key/tweak register and state datapath through every round of one block operation. Each round takes 16 cycles: a round-load strobe (`kr_ck0`) on nibble 0, then 15 shift cycles. It drives the round index, nibble index, key-register enable and final-round flag, and returns a one-cycle done pulse. It sits between the host-side handshake and `craft_key_register` / state register.

---
 rtl/craft_round_ctrl.sv | 131 +++++++++++++
 tb/tb_craft_round_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/craft_round_ctrl.sv
// Round sequencer for the nibble-serial CRAFT core: steps round/nibble counters
// through one block operation and drives the key-register strobes.
module craft_round_ctrl #(
  parameter int unsigned ROUNDS  = 32,
  parameter int unsigned ROUND_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stall,
  input  logic               abort,
  output logic               ready,
  output logic               busy,
  output logic               load_pt,
  output logic               kr_en,
  output logic               kr_ck0,
  output logic [ROUND_W-1:0] kr_round,
  output logic [3:0]         nib_idx,
  output logic               last_round,
  output logic               done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [ROUND_W-1:0] LAST_RND = ROUND_W'(ROUNDS - 1);

  state_t             r_state, w_state_nxt;
  logic [ROUND_W-1:0] r_rnd, w_rnd_nxt;
  logic [3:0]         r_nib, w_nib_nxt;
  logic               w_nib_last;
  logic               w_rnd_last;

  assign w_nib_last = (r_nib == 4'd15);
  assign w_rnd_last = (r_rnd == LAST_RND);

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_rnd   <= '0;
      r_nib   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rnd   <= w_rnd_nxt;
      r_nib   <= w_nib_nxt;
    end
  end

  // Next-state, counter update and output decode; stall only gates the strobes
  always_comb begin
    w_state_nxt = r_state;
    w_rnd_nxt   = r_rnd;
    w_nib_nxt   = r_nib;
    ready       = 1'b0;
    busy        = 1'b0;
    load_pt     = 1'b0;
    kr_en       = 1'b0;
    kr_ck0      = 1'b0;
    last_round  = 1'b0;
    done        = 1'b0;
    kr_round    = '0;
    nib_idx     = '0;
    case (r_state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) begin
          w_state_nxt = ST_INIT;
          w_rnd_nxt   = '0;
          w_nib_nxt   = '0;
        end
      end
      ST_INIT: begin
        busy     = 1'b1;
        load_pt  = 1'b1;
        kr_round = r_rnd;
        nib_idx  = r_nib;
        if (abort) begin
          w_state_nxt = ST_IDLE;
          w_rnd_nxt   = '0;
          w_nib_nxt   = '0;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        busy       = 1'b1;
        kr_en      = ~stall;
        kr_ck0     = ~stall & (r_nib == 4'd0);
        last_round = w_rnd_last;
        kr_round   = r_rnd;
        nib_idx    = r_nib;
        if (abort) begin
          w_state_nxt = ST_IDLE;
          w_rnd_nxt   = '0;
          w_nib_nxt   = '0;
        end else if (!stall) begin
          if (w_nib_last) begin
            // Final nibble of the final round: counters hold for the DONE cycle
            if (w_rnd_last) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_nib_nxt = '0;
              w_rnd_nxt = r_rnd + ROUND_W'(1);
            end
          end else begin
            w_nib_nxt = r_nib + 4'd1;
          end
        end
      end
      ST_DONE: begin
        done        = 1'b1;
        kr_round    = r_rnd;
        nib_idx     = r_nib;
        w_state_nxt = ST_IDLE;
        w_rnd_nxt   = '0;
        w_nib_nxt   = '0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_rnd_nxt   = '0;
        w_nib_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_craft_round_ctrl.sv
// Self-checking bench for craft_round_ctrl: step-count reference model compared
// every cycle, plus directed latency/strobe-count checks and a ROUNDS=1 build.
module tb_craft_round_ctrl;

  localparam int R = 32;

  logic       clk = 1'b0;
  logic       rst, start, stall, abort;
  logic       ready, busy, load_pt, kr_en, kr_ck0, last_round, done;
  logic [7:0] kr_round;
  logic [3:0] nib_idx;

  logic       start1;
  logic       ready1, busy1, load_pt1, kr_en1, kr_ck01, last_round1, done1;
  logic [7:0] kr_round1;
  logic [3:0] nib_idx1;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  craft_round_ctrl #(.ROUNDS(R), .ROUND_W(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .abort(abort),
    .ready(ready), .busy(busy), .load_pt(load_pt), .kr_en(kr_en), .kr_ck0(kr_ck0),
    .kr_round(kr_round), .nib_idx(nib_idx), .last_round(last_round), .done(done)
  );

  craft_round_ctrl #(.ROUNDS(1), .ROUND_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .stall(1'b0), .abort(1'b0),
    .ready(ready1), .busy(busy1), .load_pt(load_pt1), .kr_en(kr_en1), .kr_ck0(kr_ck01),
    .kr_round(kr_round1), .nib_idx(nib_idx1), .last_round(last_round1), .done(done1)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: an operation is a step count; -1 = load cycle,
  // 0..16R-1 = round work (round = step/16, nibble = step%16), 16R = completion.
  bit m_active = 1'b0;
  int m_step   = 0;

  always @(posedge clk) begin
    if (rst)                  m_active <= 1'b0;
    else if (!m_active) begin
      if (start) begin m_active <= 1'b1; m_step <= -1; end
    end
    else if (m_step == 16*R)  m_active <= 1'b0;
    else if (abort)           m_active <= 1'b0;
    else if (m_step < 0)      m_step <= 0;
    else if (!stall)          m_step <= m_step + 1;
  end

  always @(negedge clk) begin
    logic [18:0] exp_v, act_v;
    logic        e_rdy, e_busy, e_ld, e_en, e_ck0, e_last, e_done;
    logic [7:0]  e_rnd;
    logic [3:0]  e_nib;
    if (chk_en) begin
      e_rdy = 0; e_busy = 0; e_ld = 0; e_en = 0; e_ck0 = 0; e_last = 0; e_done = 0;
      e_rnd = 0; e_nib = 0;
      if (!m_active) e_rdy = 1;
      else if (m_step < 0) begin e_busy = 1; e_ld = 1; end
      else if (m_step == 16*R) begin
        e_done = 1; e_rnd = 8'(R - 1); e_nib = 4'd15;
      end else begin
        e_busy = 1;
        e_en   = !stall;
        e_ck0  = !stall && (m_step % 16 == 0);
        e_rnd  = 8'(m_step / 16);
        e_nib  = 4'(m_step % 16);
        e_last = (m_step / 16 == R - 1);
      end
      exp_v = {e_rdy, e_busy, e_ld, e_en, e_ck0, e_last, e_done, e_rnd, e_nib};
      act_v = {ready, busy, load_pt, kr_en, kr_ck0, last_round, done, kr_round, nib_idx};
      n_checks++;
      if (act_v !== exp_v) begin
        n_errors++;
        $display("FAIL cycle_model t=%0t actual=%h required=%h", $time, act_v, exp_v);
      end
    end
  end

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  // One operation from accept; cycle numbers are relative to the accept edge.
  task automatic run_op(input int s1, input int l1, input int s2, input int l2,
                        input int ab, input bit hold_start,
                        output int done_cyc, output int ck0s,
                        output int lr_first, output int lr_cnt);
    done_cyc = -1; ck0s = 0; lr_first = -1; lr_cnt = 0;
    start = 1'b1;
    step_clk();
    if (!hold_start) start = 1'b0;
    for (int c = 1; c < 3000 && done_cyc < 0; c++) begin
      stall = ((c >= s1) && (c < s1 + l1)) || ((c >= s2) && (c < s2 + l2));
      abort = (c == ab);
      #1;
      if (kr_ck0) ck0s++;
      if (last_round) begin
        lr_cnt++;
        if (lr_first < 0) lr_first = c;
      end
      if (done) done_cyc = c;
      step_clk();
      if (c == ab) begin done_cyc = -2; break; end
    end
    stall = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    int d, ck, lf, lc;
    rst = 1'b1; start = 1'b0; stall = 1'b0; abort = 1'b0; start1 = 1'b0;
    repeat (2) step_clk();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_kr_round", kr_round, 0);

    // ROUNDS=1 build
    start1 = 1'b1;
    step_clk();
    start1 = 1'b0;
    d = -1; ck = 0; lc = 0;
    for (int c = 1; c < 100 && d < 0; c++) begin
      #1;
      if (kr_ck01) ck++;
      if (last_round1) lc++;
      if (done1) d = c;
      step_clk();
    end
    chk("r1_done_cycle", d, 18);
    chk("r1_ck0_pulses", ck, 1);
    chk("r1_last_round_cycles", lc, 16);

    // Nominal
    run_op(0, 0, 0, 0, 0, 0, d, ck, lf, lc);
    chk("nom_done_cycle", d, 514);
    chk("nom_ck0_pulses", ck, 32);
    chk("nom_last_first", lf, 498);
    chk("nom_last_cycles", lc, 16);
    chk("nom_ready_515", ready, 1);

    // Stalls: 3 cycles at round 5 nib 0, then 2 cycles at round 5 nib 7
    run_op(82, 3, 92, 2, 0, 0, d, ck, lf, lc);
    chk("stall_done_cycle", d, 519);
    chk("stall_ck0_pulses", ck, 32);

    // Abort at round 10 nib 4 (cycle 166), then immediate restart
    run_op(0, 0, 0, 0, 166, 0, d, ck, lf, lc);
    chk("abort_no_done", d, -2);
    chk("abort_ready", ready, 1);
    chk("abort_kr_round", kr_round, 0);
    chk("abort_done_low", done, 0);
    run_op(0, 0, 0, 0, 0, 0, d, ck, lf, lc);
    chk("restart_done_cycle", d, 514);

    // start held high: back-to-back operations
    run_op(0, 0, 0, 0, 0, 1, d, ck, lf, lc);
    chk("b2b_first_done_514", d, 514);
    chk("b2b_idle_gap_ready", ready, 1);
    run_op(0, 0, 0, 0, 0, 1, d, ck, lf, lc);
    chk("b2b_second_done_1029", d + 515, 1029);
    start = 1'b0;
    step_clk();

    // Reset at round 20, held 2 cycles
    start = 1'b1;
    step_clk();
    start = 1'b0;
    repeat (321) step_clk();
    chk("pre_rst_round", kr_round, 20);
    rst = 1'b1;
    step_clk();
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_kr_round", kr_round, 0);
    chk("mid_rst_nib", nib_idx, 0);
    chk("mid_rst_done", done, 0);
    step_clk();
    rst = 1'b0;
    run_op(0, 0, 0, 0, 0, 0, d, ck, lf, lc);
    chk("post_rst_done_cycle", d, 514);
    chk("post_rst_ck0_pulses", ck, 32);

    // Randomized traffic, checked cycle by cycle against the model
    for (int i = 0; i < 8000; i++) begin
      start = ($urandom_range(7) == 0);
      stall = ($urandom_range(3) == 0);
      abort = ($urandom_range(699) == 0);
      rst   = ($urandom_range(2999) == 0);
      step_clk();
    end
    start = 1'b0; stall = 1'b0; abort = 1'b0; rst = 1'b0;
    repeat (600) step_clk();
    chk("drain_ready", ready, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
